// File: rtl/lab1_imul_dot_accum_pkg.sv
// Shared types and message layout for the product-stream dot-product accumulator.
// Field offsets below describe the default configuration (32-bit products, 40-bit sum, 8-bit count).
package lab1_imul_dot_accum_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam int P_NBITS     = 32;
    localparam int P_ACC_NBITS = 40;
    localparam int P_CNT_NBITS = 8;

    localparam int LAST_BIT  = P_NBITS;
    localparam int COUNT_LSB = P_ACC_NBITS;
    localparam int OVF_BIT   = P_ACC_NBITS + P_CNT_NBITS;

endpackage

// File: rtl/lab1_imul_dot_accum_dpath.sv
// Accumulator datapath: sum/count/ovf registers with a load-or-accumulate update.
// load_en starts a new vector from the current product; acc_en adds it to the running sum.
module lab1_imul_dot_accum_dpath
    import lab1_imul_dot_accum_pkg::*;
#(
    parameter int p_nbits     = P_NBITS,
    parameter int p_acc_nbits = P_ACC_NBITS,
    parameter int p_cnt_nbits = P_CNT_NBITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_en,
    input  logic                   acc_en,
    input  logic [p_nbits-1:0]     product,
    output logic [p_acc_nbits-1:0] sum,
    output logic [p_cnt_nbits-1:0] count,
    output logic                   ovf
);

    logic [p_acc_nbits-1:0] prod_ext;
    logic [p_acc_nbits:0]   add_res;

    assign prod_ext = p_acc_nbits'(product);
    // Extra MSB of the add is the carry-out that feeds the sticky overflow flag.
    assign add_res  = {1'b0, sum} + {1'b0, prod_ext};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (load_en) begin
            sum   <= prod_ext;
            count <= p_cnt_nbits'(1);
            ovf   <= 1'b0;
        end else if (acc_en) begin
            sum   <= add_res[p_acc_nbits-1:0];
            if (count != '1)
                count <= count + p_cnt_nbits'(1);
            ovf   <= ovf | add_res[p_acc_nbits];
        end
    end

endmodule

// File: rtl/lab1_imul_dot_accum.sv
// Dot-product reduction of a val/rdy product stream; emits {ovf, count, sum} per 'last'-delimited vector.
// The FSM holds the result in DONE and can reload from a new vector in the same cycle the result leaves.
module lab1_imul_dot_accum
    import lab1_imul_dot_accum_pkg::*;
#(
    parameter int p_nbits     = P_NBITS,
    parameter int p_acc_nbits = P_ACC_NBITS,
    parameter int p_cnt_nbits = P_CNT_NBITS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               istream_val,
    output logic                               istream_rdy,
    input  logic [p_nbits:0]                   istream_msg,
    output logic                               ostream_val,
    input  logic                               ostream_rdy,
    output logic [p_cnt_nbits+p_acc_nbits:0]   ostream_msg
);

    state_t                 state, state_nxt;
    logic                   load_en, acc_en;
    logic                   last;
    logic [p_acc_nbits-1:0] sum;
    logic [p_cnt_nbits-1:0] count;
    logic                   ovf;

    assign last = istream_msg[p_nbits];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        istream_rdy = 1'b1;
        ostream_val = 1'b0;
        load_en     = 1'b0;
        acc_en      = 1'b0;
        case (state)
            IDLE: begin
                if (istream_val) begin
                    load_en   = 1'b1;
                    state_nxt = last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (istream_val) begin
                    acc_en    = 1'b1;
                    state_nxt = last ? DONE : ACCUM;
                end
            end
            DONE: begin
                ostream_val = 1'b1;
                // Input may only advance while the result is leaving, keeping back-to-back vectors bubble-free.
                istream_rdy = ostream_rdy;
                if (ostream_rdy) begin
                    if (istream_val) begin
                        load_en   = 1'b1;
                        state_nxt = last ? DONE : ACCUM;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    lab1_imul_dot_accum_dpath #(
        .p_nbits     (p_nbits),
        .p_acc_nbits (p_acc_nbits),
        .p_cnt_nbits (p_cnt_nbits)
    ) dpath (
        .clk     (clk),
        .reset   (reset),
        .load_en (load_en),
        .acc_en  (acc_en),
        .product (istream_msg[p_nbits-1:0]),
        .sum     (sum),
        .count   (count),
        .ovf     (ovf)
    );

    assign ostream_msg = {ovf, count, sum};

endmodule
